// File: rtl/trap_state.sv
// rtl/trap_state.sv - machine/supervisor trap state, xRET handling and trap CSR write path
//
// Ports:
//   clk, reset           clock; synchronous active-high reset (overrides StallW)
//   StallW               hold all state this cycle
//   TrapM, InterruptM,   trap taken / is interrupt / cause code / delegate to S
//   CauseM, DelegateM
//   PCM, TrapValM        trapping PC and value for xTVAL
//   mretM, sretM         return instruction committing
//   CSRWriteM, CSRAdrM,  CSR write strobe, address, data
//   CSRWriteValM
//   PrivilegeModeW       current privilege (3=M, 1=S, 0=U)
//   STATUS_*             mstatus interrupt stack fields
//   *_REGW               xEPC/xCAUSE/xTVAL/xTVEC registers
//   TrapVectorM, RetPCM  combinational redirect targets
module trap_state #(
    parameter int XLEN        = 64,
    parameter int S_SUPPORTED = 1,
    parameter int U_SUPPORTED = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallW,
    input  logic            TrapM,
    input  logic            InterruptM,
    input  logic [3:0]      CauseM,
    input  logic            DelegateM,
    input  logic [XLEN-1:0] PCM,
    input  logic [XLEN-1:0] TrapValM,
    input  logic            mretM,
    input  logic            sretM,
    input  logic            CSRWriteM,
    input  logic [11:0]     CSRAdrM,
    input  logic [XLEN-1:0] CSRWriteValM,
    output logic [1:0]      PrivilegeModeW,
    output logic            STATUS_MIE,
    output logic            STATUS_SIE,
    output logic            STATUS_MPIE,
    output logic            STATUS_SPIE,
    output logic            STATUS_SPP,
    output logic [1:0]      STATUS_MPP,
    output logic [XLEN-1:0] MEPC_REGW,
    output logic [XLEN-1:0] SEPC_REGW,
    output logic [XLEN-1:0] MCAUSE_REGW,
    output logic [XLEN-1:0] SCAUSE_REGW,
    output logic [XLEN-1:0] MTVAL_REGW,
    output logic [XLEN-1:0] STVAL_REGW,
    output logic [XLEN-1:0] MTVEC_REGW,
    output logic [XLEN-1:0] STVEC_REGW,
    output logic [XLEN-1:0] TrapVectorM,
    output logic [XLEN-1:0] RetPCM
);

    localparam bit S_EN = (S_SUPPORTED != 0);
    localparam logic [1:0] MPP_AFTER_MRET = (U_SUPPORTED != 0) ? 2'd0 : 2'd3;

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic            toS;
    logic [XLEN-1:0] epcVal;
    logic [XLEN-1:0] causeVal;
    logic [XLEN-1:0] csrEpcVal;
    logic [XLEN-1:0] csrTvecVal;
    logic [XLEN-1:0] selTvec;
    logic [XLEN-1:0] tvecBase;
    logic [XLEN-1:0] causeOffset;
    logic [1:0]      mppWrite;
    logic            mppLegal;

    // Delegation only takes effect when S mode exists.
    assign toS      = DelegateM & S_EN;
    assign epcVal   = PCM & ~ONE;
    assign causeVal = {InterruptM, {(XLEN-5){1'b0}}, CauseM};

    assign csrEpcVal  = CSRWriteValM & ~ONE;
    // Reserved tvec modes (2,3) collapse to direct mode.
    assign csrTvecVal = {CSRWriteValM[XLEN-1:2], CSRWriteValM[1] ? 2'b00 : CSRWriteValM[1:0]};

    // MPP is WARL: reserved encoding 2, and S when S is absent, keep the old value.
    assign mppWrite = CSRWriteValM[12:11];
    assign mppLegal = (mppWrite != 2'd2) && !((mppWrite == 2'd1) && !S_EN);

    assign selTvec     = toS ? STVEC_REGW : MTVEC_REGW;
    assign tvecBase    = {selTvec[XLEN-1:2], 2'b00};
    assign causeOffset = {{(XLEN-6){1'b0}}, CauseM, 2'b00};

    always_comb begin
        TrapVectorM = tvecBase;
        if (selTvec[1:0] == 2'd1 && InterruptM)
            TrapVectorM = tvecBase + causeOffset;
    end

    assign RetPCM = mretM ? MEPC_REGW : SEPC_REGW;

    always_ff @(posedge clk) begin
        if (reset) begin
            PrivilegeModeW <= 2'd3;
            STATUS_MIE     <= 1'b0;
            STATUS_SIE     <= 1'b0;
            STATUS_MPIE    <= 1'b0;
            STATUS_SPIE    <= 1'b0;
            STATUS_SPP     <= 1'b0;
            STATUS_MPP     <= 2'd0;
            MEPC_REGW      <= '0;
            SEPC_REGW      <= '0;
            MCAUSE_REGW    <= '0;
            SCAUSE_REGW    <= '0;
            MTVAL_REGW     <= '0;
            STVAL_REGW     <= '0;
            MTVEC_REGW     <= '0;
            STVEC_REGW     <= '0;
        end else if (!StallW) begin
            if (TrapM) begin
                if (toS) begin
                    SEPC_REGW      <= epcVal;
                    SCAUSE_REGW    <= causeVal;
                    STVAL_REGW     <= TrapValM;
                    STATUS_SPIE    <= STATUS_SIE;
                    STATUS_SIE     <= 1'b0;
                    STATUS_SPP     <= PrivilegeModeW[0];
                    PrivilegeModeW <= 2'd1;
                end else begin
                    MEPC_REGW      <= epcVal;
                    MCAUSE_REGW    <= causeVal;
                    MTVAL_REGW     <= TrapValM;
                    STATUS_MPIE    <= STATUS_MIE;
                    STATUS_MIE     <= 1'b0;
                    STATUS_MPP     <= PrivilegeModeW;
                    PrivilegeModeW <= 2'd3;
                end
            end else if (mretM) begin
                PrivilegeModeW <= STATUS_MPP;
                STATUS_MIE     <= STATUS_MPIE;
                STATUS_MPIE    <= 1'b1;
                STATUS_MPP     <= MPP_AFTER_MRET;
            end else if (sretM) begin
                // Still claims the cycle without S mode, so a same-cycle CSR write is dropped.
                if (S_EN) begin
                    PrivilegeModeW <= {1'b0, STATUS_SPP};
                    STATUS_SIE     <= STATUS_SPIE;
                    STATUS_SPIE    <= 1'b1;
                    STATUS_SPP     <= 1'b0;
                end
            end else if (CSRWriteM) begin
                case (CSRAdrM)
                    12'h300: begin
                        STATUS_MIE  <= CSRWriteValM[3];
                        STATUS_MPIE <= CSRWriteValM[7];
                        if (mppLegal) STATUS_MPP <= mppWrite;
                        if (S_EN) begin
                            STATUS_SIE  <= CSRWriteValM[1];
                            STATUS_SPIE <= CSRWriteValM[5];
                            STATUS_SPP  <= CSRWriteValM[8];
                        end
                    end
                    12'h341: MEPC_REGW   <= csrEpcVal;
                    12'h342: MCAUSE_REGW <= CSRWriteValM;
                    12'h343: MTVAL_REGW  <= CSRWriteValM;
                    12'h305: MTVEC_REGW  <= csrTvecVal;
                    12'h141: if (S_EN) SEPC_REGW   <= csrEpcVal;
                    12'h142: if (S_EN) SCAUSE_REGW <= CSRWriteValM;
                    12'h143: if (S_EN) STVAL_REGW  <= CSRWriteValM;
                    12'h105: if (S_EN) STVEC_REGW  <= csrTvecVal;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trap_state.sv
// tb/tb_trap_state.sv - directed self-checking bench for trap_state
module tb_trap_state;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset, StallW, TrapM, InterruptM, DelegateM;
    logic [3:0]      CauseM;
    logic [XLEN-1:0] PCM, TrapValM, CSRWriteValM;
    logic            mretM, sretM, CSRWriteM;
    logic [11:0]     CSRAdrM;
    logic [1:0]      PrivilegeModeW, STATUS_MPP;
    logic            STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP;
    logic [XLEN-1:0] MEPC_REGW, SEPC_REGW, MCAUSE_REGW, SCAUSE_REGW;
    logic [XLEN-1:0] MTVAL_REGW, STVAL_REGW, MTVEC_REGW, STVEC_REGW;
    logic [XLEN-1:0] TrapVectorM, RetPCM;

    int checks = 0;
    int errors = 0;

    trap_state #(.XLEN(XLEN), .S_SUPPORTED(1), .U_SUPPORTED(1)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .TrapM(TrapM),
        .InterruptM(InterruptM), .CauseM(CauseM), .DelegateM(DelegateM),
        .PCM(PCM), .TrapValM(TrapValM), .mretM(mretM), .sretM(sretM),
        .CSRWriteM(CSRWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM),
        .PrivilegeModeW(PrivilegeModeW), .STATUS_MIE(STATUS_MIE),
        .STATUS_SIE(STATUS_SIE), .STATUS_MPIE(STATUS_MPIE),
        .STATUS_SPIE(STATUS_SPIE), .STATUS_SPP(STATUS_SPP),
        .STATUS_MPP(STATUS_MPP), .MEPC_REGW(MEPC_REGW), .SEPC_REGW(SEPC_REGW),
        .MCAUSE_REGW(MCAUSE_REGW), .SCAUSE_REGW(SCAUSE_REGW),
        .MTVAL_REGW(MTVAL_REGW), .STVAL_REGW(STVAL_REGW),
        .MTVEC_REGW(MTVEC_REGW), .STVEC_REGW(STVEC_REGW),
        .TrapVectorM(TrapVectorM), .RetPCM(RetPCM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        StallW = 0; TrapM = 0; InterruptM = 0; DelegateM = 0; CauseM = 0;
        PCM = 0; TrapValM = 0; mretM = 0; sretM = 0;
        CSRWriteM = 0; CSRAdrM = 0; CSRWriteValM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] adr, input logic [XLEN-1:0] val);
        idle();
        CSRWriteM = 1; CSRAdrM = adr; CSRWriteValM = val;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        chk("rst_priv", 64'(PrivilegeModeW), 64'd3);
        chk("rst_mie", 64'(STATUS_MIE), 64'd0);
        chk("rst_mpp", 64'(STATUS_MPP), 64'd0);
        chk("rst_mepc", MEPC_REGW, 64'd0);
        chk("rst_mtvec", MTVEC_REGW, 64'd0);

        // Vectored interrupt trap to M
        csr_wr(12'h300, 64'h8);
        chk("mie_set", 64'(STATUS_MIE), 64'd1);
        csr_wr(12'h305, 64'h8000_0001);
        chk("mtvec_wr", MTVEC_REGW, 64'h8000_0001);
        TrapM = 1; InterruptM = 1; CauseM = 4'd7; PCM = 64'h2003; TrapValM = 64'h55;
        #1;
        chk("tvec_vectored", TrapVectorM, 64'h8000_001C);
        tick();
        idle();
        chk("m_mepc", MEPC_REGW, 64'h2002);
        chk("m_mcause", MCAUSE_REGW, 64'h8000_0000_0000_0007);
        chk("m_mtval", MTVAL_REGW, 64'h55);
        chk("m_mie", 64'(STATUS_MIE), 64'd0);
        chk("m_mpie", 64'(STATUS_MPIE), 64'd1);
        chk("m_mpp", 64'(STATUS_MPP), 64'd3);
        chk("m_priv", 64'(PrivilegeModeW), 64'd3);

        // Drop to U with SIE=1 via mret (MPP=0)
        csr_wr(12'h300, 64'h2);
        csr_wr(12'h105, 64'h4000_0005);
        chk("stvec_wr", STVEC_REGW, 64'h4000_0005);
        mretM = 1;
        #1;
        chk("retpc_mret1", RetPCM, 64'h2002);
        tick();
        idle();
        chk("mret_u_priv", 64'(PrivilegeModeW), 64'd0);
        chk("mret_u_mpie", 64'(STATUS_MPIE), 64'd1);

        // Delegated exception to S; vectored stvec ignored for exceptions
        TrapM = 1; DelegateM = 1; CauseM = 4'd8; PCM = 64'h1001; TrapValM = 64'h77;
        #1;
        chk("tvec_s_exc", TrapVectorM, 64'h4000_0004);
        tick();
        idle();
        chk("s_sepc", SEPC_REGW, 64'h1000);
        chk("s_scause", SCAUSE_REGW, 64'd8);
        chk("s_stval", STVAL_REGW, 64'h77);
        chk("s_spp", 64'(STATUS_SPP), 64'd0);
        chk("s_spie", 64'(STATUS_SPIE), 64'd1);
        chk("s_sie", 64'(STATUS_SIE), 64'd0);
        chk("s_priv", 64'(PrivilegeModeW), 64'd1);
        chk("s_mepc_kept", MEPC_REGW, 64'h2002);

        // sret back to U
        sretM = 1;
        #1;
        chk("retpc_sret", RetPCM, 64'h1000);
        tick();
        idle();
        chk("sret_priv", 64'(PrivilegeModeW), 64'd0);
        chk("sret_sie", 64'(STATUS_SIE), 64'd1);

        // mret to S
        csr_wr(12'h300, 64'h880);
        chk("mpp_wr1", 64'(STATUS_MPP), 64'd1);
        chk("mpie_wr1", 64'(STATUS_MPIE), 64'd1);
        mretM = 1;
        #1;
        chk("retpc_mret2", RetPCM, 64'h2002);
        tick();
        idle();
        chk("mret_priv", 64'(PrivilegeModeW), 64'd1);
        chk("mret_mie", 64'(STATUS_MIE), 64'd1);
        chk("mret_mpie", 64'(STATUS_MPIE), 64'd1);
        chk("mret_mpp", 64'(STATUS_MPP), 64'd0);

        // Trap + mret + CSR write same cycle: trap only
        TrapM = 1; CauseM = 4'd2; PCM = 64'h3000; mretM = 1;
        CSRWriteM = 1; CSRAdrM = 12'h341; CSRWriteValM = 64'hDEAD;
        tick();
        idle();
        chk("prio_mepc", MEPC_REGW, 64'h3000);
        chk("prio_mcause", MCAUSE_REGW, 64'd2);
        chk("prio_priv", 64'(PrivilegeModeW), 64'd3);
        chk("prio_mpp", 64'(STATUS_MPP), 64'd1);
        chk("prio_mpie", 64'(STATUS_MPIE), 64'd1);

        // WARL fields
        csr_wr(12'h300, 64'h1000);
        chk("mpp_reserved", 64'(STATUS_MPP), 64'd1);
        chk("mpie_cleared", 64'(STATUS_MPIE), 64'd0);
        csr_wr(12'h305, 64'h8000_0103);
        chk("mtvec_mode3", MTVEC_REGW, 64'h8000_0100);
        csr_wr(12'h341, 64'h4567);
        chk("mepc_bit0", MEPC_REGW, 64'h4566);

        // Stall holds state; combinational outputs still track
        StallW = 1; TrapM = 1; CauseM = 4'd3; PCM = 64'h5000;
        #1;
        chk("stall_tvec", TrapVectorM, 64'h8000_0100);
        tick();
        chk("stall_mepc", MEPC_REGW, 64'h4566);
        chk("stall_mcause", MCAUSE_REGW, 64'd2);

        // Reset during stall
        reset = 1;
        tick();
        reset = 0;
        idle();
        chk("rst2_priv", 64'(PrivilegeModeW), 64'd3);
        chk("rst2_mepc", MEPC_REGW, 64'd0);
        chk("rst2_sepc", SEPC_REGW, 64'd0);
        chk("rst2_mtvec", MTVEC_REGW, 64'd0);
        chk("rst2_stvec", STVEC_REGW, 64'd0);
        chk("rst2_mpp", 64'(STATUS_MPP), 64'd0);
        chk("rst2_sie", 64'(STATUS_SIE), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
